serial_subtractor_8bit: RTL and testbench



---
 rtl/serial_subtractor_8bit.sv | 113 +++++++++++
 tb/tb_serial_subtractor_8bit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: one full-subtractor slice iterated LSB first, computing
// a - b - bin over WIDTH clocks behind a start/busy/done handshake.
module serial_subtractor_8bit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start; diff/bout hold the last result
  // RUN   | one bit of the difference produced per clock, LSB first
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_d;
  logic             brw_nxt;

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bit_d   = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
    brw_nxt = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        r_sr_d = {bit_d, r_sr_q[WIDTH-1:1]};
        brw_d  = brw_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        // Last slice: publish the finished word together with the final borrow
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d  = {bit_d, r_sr_q[WIDTH-1:1]};
          bout_d  = brw_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed and random checks of serial_subtractor_8bit against a 9-bit
// a - b - bin reference kept in a result scoreboard.
module tb_serial_subtractor_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic [7:0] diff;
  logic       bout;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int cyc = 0;
  logic [8:0] sb[$];

  serial_subtractor_8bit #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .diff(diff), .bout(bout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {8'd0, c};
  endfunction

  // Scoreboard consumer: every done pulse must retire exactly one expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      logic [8:0] e;
      done_cnt++;
      chk("done_has_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("result", int'({bout, diff}), int'(e));
      end
    end
  end

  task automatic drive_start(input logic [7:0] x, input logic [7:0] y, input logic c);
    a = x; b = y; bin = c; start = 1'b1;
    sb.push_back(model(x, y, c));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(done), 1);
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic c);
    drive_start(x, y, c);
    wait_done("done_timeout");
    @(negedge clk);
  endtask

  initial begin
    int n;
    int t0, t1, t2;
    int exp_dones;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_diff", int'(diff), 0);
    chk("rst_bout", int'(bout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // 100 - 37: busy for exactly 8 cycles, done for exactly one
    drive_start(8'd100, 8'd37, 1'b0);
    n = 0;
    while (busy && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 8);
    chk("done_at_busy_fall", int'(done), 1);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("diff_hold_idle", int'(diff), 63);

    // Previous result must survive into the next operation until it completes
    drive_start(8'd37, 8'd100, 1'b0);
    repeat (3) @(negedge clk);
    chk("diff_hold_run", int'(diff), 63);
    wait_done("done_timeout");
    @(negedge clk);
    chk("diff_37_100", int'(diff), 193);
    chk("bout_37_100", int'(bout), 1);

    run_op(8'd0, 8'd0, 1'b1);
    run_op(8'd255, 8'd255, 1'b1);
    run_op(8'd255, 8'd0, 1'b0);

    // start while busy is ignored
    exp_dones = done_cnt + 1;
    drive_start(8'd200, 8'd50, 1'b0);
    @(negedge clk);
    a = 8'd1; b = 8'd1; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("done_timeout");
    chk("diff_ignored_start", int'(diff), 150);
    repeat (12) @(negedge clk);
    chk("single_done", done_cnt, exp_dones);
    chk("busy_after_ignored", int'(busy), 0);

    // Asynchronous reset mid-operation
    drive_start(8'd50, 8'd20, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_diff", int'(diff), 0);
    chk("arst_bout", int'(bout), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_done_after_abort", int'(busy), 0);
    run_op(8'd10, 8'd3, 1'b0);
    chk("diff_after_reset", int'(diff), 7);

    // Back-to-back with start held high
    a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
    sb.push_back(model(8'd100, 8'd37, 1'b0));
    @(negedge clk);
    wait_done("b2b_timeout");
    t0 = cyc;
    a = 8'd37; b = 8'd100;
    sb.push_back(model(8'd37, 8'd100, 1'b0));
    @(negedge clk);
    chk("b2b_busy_rises", int'(busy), 1);
    chk("b2b_done_falls", int'(done), 0);
    wait_done("b2b_timeout");
    t1 = cyc;
    a = 8'd5; b = 8'd5;
    sb.push_back(model(8'd5, 8'd5, 1'b0));
    @(negedge clk);
    wait_done("b2b_timeout");
    t2 = cyc;
    start = 1'b0;
    chk("b2b_diff_last", int'(diff), 0);
    chk("b2b_bout_last", int'(bout), 0);
    chk("b2b_spacing1", t1 - t0, 9);
    chk("b2b_spacing2", t2 - t1, 9);
    @(negedge clk);

    // Random vectors
    for (int i = 0; i < 1000; i++)
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
